// File: rtl/kay_mem_responder_pkg.sv
// Shared types and constants for the kay memory responder.
// The package is imported by the interface, the RAM and the responder top.
package kayrv32_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // RV32I canonical NOP (addi x0, x0, 0)
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    PEND_I = 2'd2
  } state_e;

endpackage

// File: rtl/kay_mem_responder_if.sv
// IBUS/DBUS bundle between the core (master) and the memory responder (slave).
interface kay_mem_responder_if;
  import kayrv32_mem_pkg::*;

  logic [WORD_W-1:0] i_iMem_Addr;
  logic              i_iMem_ReadEn;
  logic [WORD_W-1:0] o_iMem_Data;
  logic [WORD_W-1:0] i_dMem_Addr;
  logic [WORD_W-1:0] i_dMem_DataWrite;
  logic [BE_W-1:0]   i_dMem_ByteEn;
  logic              i_dMem_ReadEn;
  logic              i_dMem_WriteEn;
  logic [WORD_W-1:0] o_dMem_DataRead;
  logic              o_Stall;
  logic              o_Fault;

  modport slave (
    input  i_iMem_Addr, i_iMem_ReadEn,
    input  i_dMem_Addr, i_dMem_DataWrite, i_dMem_ByteEn, i_dMem_ReadEn, i_dMem_WriteEn,
    output o_iMem_Data, o_dMem_DataRead, o_Stall, o_Fault
  );

  modport master (
    output i_iMem_Addr, i_iMem_ReadEn,
    output i_dMem_Addr, i_dMem_DataWrite, i_dMem_ByteEn, i_dMem_ReadEn, i_dMem_WriteEn,
    input  o_iMem_Data, o_dMem_DataRead, o_Stall, o_Fault
  );

endinterface

// File: rtl/kay_mem_sram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Write-first: the read register returns the merged word on a store.
module kay_mem_sram
  import kayrv32_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [BE_W-1:0]   we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] merged_d;

  always_comb begin
    merged_d = mem_q[addr_i];
    for (int b = 0; b < BE_W; b++) begin
      if (we_i[b]) merged_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (|we_i) mem_q[addr_i] <= merged_d;
      rdata_q <= merged_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kay_mem_responder.sv
// IBUS/DBUS memory responder: arbitration, wait states and stall over one shared RAM.
// Optional access/stall counters enabled by KAYRV32_MEM_PERFCNT_EN.
module kay_mem_responder
  import kayrv32_mem_pkg::*;
#(
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [WORD_W-1:0] RESET_INSTR = NOP_INSTR
) (
  input  logic                i_Clk,
  input  logic                i_Rstn,
  kay_mem_responder_if.slave  bus
`ifdef KAYRV32_MEM_PERFCNT_EN
  ,
  output logic [WORD_W-1:0]   o_AccessCnt,
  output logic [WORD_W-1:0]   o_StallCnt
`endif
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] ADDR_LIM = WORD_W'(DEPTH * 4);
  localparam logic [3:0]        CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] ia_q, ia_d, da_q, da_d, dwd_q, dwd_d;
  logic [BE_W-1:0]   dbe_q, dbe_d;
  logic              ire_q, ire_d, dre_q, dre_d, dwe_q, dwe_d;

  logic              ifresh_q, ioor_q, dfresh_q, door_q, fault_q;
  logic [WORD_W-1:0] ihold_q, dhold_q;

  logic              p_d, p_i;
  logic [WORD_W-1:0] eff_ia, eff_da, eff_dwd, op_addr;
  logic [BE_W-1:0]   eff_dbe;
  logic              eff_ire, eff_dre, eff_dwe, op_oor;
  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [WORD_W-1:0] sram_rdata;

  // Requests come straight from the bus in IDLE and from the latched copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      eff_ia  = bus.i_iMem_Addr;
      eff_ire = bus.i_iMem_ReadEn;
      eff_da  = bus.i_dMem_Addr;
      eff_dwd = bus.i_dMem_DataWrite;
      eff_dbe = bus.i_dMem_ByteEn;
      eff_dre = bus.i_dMem_ReadEn;
      eff_dwe = bus.i_dMem_WriteEn;
    end else begin
      eff_ia  = ia_q;
      eff_ire = ire_q;
      eff_da  = da_q;
      eff_dwd = dwd_q;
      eff_dbe = dbe_q;
      eff_dre = dre_q;
      eff_dwe = dwe_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ia_d    = ia_q;
    ire_d   = ire_q;
    da_d    = da_q;
    dwd_d   = dwd_q;
    dbe_d   = dbe_q;
    dre_d   = dre_q;
    dwe_d   = dwe_q;
    p_d     = 1'b0;
    p_i     = 1'b0;
    case (state_q)
      IDLE: begin
        if (WAIT_STATES == 0) begin
          if (eff_dre || eff_dwe) begin
            p_d = 1'b1;
            if (eff_ire) begin
              ia_d    = eff_ia;
              ire_d   = 1'b1;
              state_d = PEND_I;
            end
          end else if (eff_ire) begin
            p_i = 1'b1;
          end
        end else if (eff_ire || eff_dre || eff_dwe) begin
          ia_d    = eff_ia;
          ire_d   = eff_ire;
          da_d    = eff_da;
          dwd_d   = eff_dwd;
          dbe_d   = eff_dbe;
          dre_d   = eff_dre;
          dwe_d   = eff_dwe;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (dre_q || dwe_q) begin
            p_d     = 1'b1;
            state_d = ire_q ? PEND_I : IDLE;
          end else begin
            p_i     = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PEND_I: begin
        p_i     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range stores never reach the RAM; a ReadEn+WriteEn pair acts as a store.
  assign op_addr = p_d ? eff_da : eff_ia;
  assign op_oor  = (op_addr >= ADDR_LIM);
  assign sram_en = (p_d || p_i) && !op_oor;
  assign sram_we = (p_d && eff_dwe && !op_oor) ? eff_dbe : '0;

  kay_mem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk_i   (i_Clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (op_addr[AW+1:2]),
    .wdata_i (eff_dwd),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ia_q     <= '0;
      ire_q    <= 1'b0;
      da_q     <= '0;
      dwd_q    <= '0;
      dbe_q    <= '0;
      dre_q    <= 1'b0;
      dwe_q    <= 1'b0;
      ifresh_q <= 1'b0;
      ioor_q   <= 1'b0;
      dfresh_q <= 1'b0;
      door_q   <= 1'b0;
      fault_q  <= 1'b0;
      ihold_q  <= RESET_INSTR;
      dhold_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ia_q     <= ia_d;
      ire_q    <= ire_d;
      da_q     <= da_d;
      dwd_q    <= dwd_d;
      dbe_q    <= dbe_d;
      dre_q    <= dre_d;
      dwe_q    <= dwe_d;
      ifresh_q <= p_i;
      ioor_q   <= op_oor;
      dfresh_q <= p_d && eff_dre && !eff_dwe;
      door_q   <= op_oor;
      fault_q  <= (p_d && (op_oor || (eff_dre && eff_dwe))) || (p_i && op_oor);
      ihold_q  <= bus.o_iMem_Data;
      dhold_q  <= bus.o_dMem_DataRead;
    end
  end

  // Read ports show the RAM register right after their own read, else the held value.
  assign bus.o_iMem_Data     = ifresh_q ? (ioor_q ? '0 : sram_rdata) : ihold_q;
  assign bus.o_dMem_DataRead = dfresh_q ? (door_q ? '0 : sram_rdata) : dhold_q;
  assign bus.o_Stall         = (state_q != IDLE);
  assign bus.o_Fault         = fault_q;

`ifdef KAYRV32_MEM_PERFCNT_EN
  logic [WORD_W-1:0] acc_cnt_q, stall_cnt_q;

  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (p_d || p_i) acc_cnt_q <= acc_cnt_q + 1'b1;
      if (state_q != IDLE) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_AccessCnt = acc_cnt_q;
  assign o_StallCnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kay_mem_responder.sv
// Directed bench for kay_mem_responder: one instance with no wait states, one with three.
module tb_kay_mem_responder;
  import kayrv32_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  kay_mem_responder_if bus_a ();
  kay_mem_responder_if bus_b ();

`ifdef KAYRV32_MEM_PERFCNT_EN
  logic [31:0] acc_a, stl_a, acc_b, stl_b;
`endif

  kay_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut_a (
    .i_Clk  (clk),
    .i_Rstn (rst_n),
    .bus    (bus_a)
`ifdef KAYRV32_MEM_PERFCNT_EN
    ,
    .o_AccessCnt (acc_a),
    .o_StallCnt  (stl_a)
`endif
  );

  kay_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut_b (
    .i_Clk  (clk),
    .i_Rstn (rst_n),
    .bus    (bus_b)
`ifdef KAYRV32_MEM_PERFCNT_EN
    ,
    .o_AccessCnt (acc_b),
    .o_StallCnt  (stl_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    bus_a.i_iMem_Addr      = '0;
    bus_a.i_iMem_ReadEn    = 1'b0;
    bus_a.i_dMem_Addr      = '0;
    bus_a.i_dMem_DataWrite = '0;
    bus_a.i_dMem_ByteEn    = '0;
    bus_a.i_dMem_ReadEn    = 1'b0;
    bus_a.i_dMem_WriteEn   = 1'b0;
  endtask

  task automatic b_idle();
    bus_b.i_iMem_Addr      = '0;
    bus_b.i_iMem_ReadEn    = 1'b0;
    bus_b.i_dMem_Addr      = '0;
    bus_b.i_dMem_DataWrite = '0;
    bus_b.i_dMem_ByteEn    = '0;
    bus_b.i_dMem_ReadEn    = 1'b0;
    bus_b.i_dMem_WriteEn   = 1'b0;
  endtask

  task automatic a_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_a.i_dMem_Addr      = addr;
    bus_a.i_dMem_DataWrite = data;
    bus_a.i_dMem_ByteEn    = be;
    bus_a.i_dMem_WriteEn   = 1'b1;
    step();
    a_idle();
  endtask

  task automatic a_load(input logic [31:0] addr);
    bus_a.i_dMem_Addr   = addr;
    bus_a.i_dMem_ReadEn = 1'b1;
    step();
    a_idle();
  endtask

  // Holds the current B request until the stall drops (bounded); returns stalled cycles.
  task automatic b_run(output int cyc);
    step();
    cyc = 0;
    while (bus_b.o_Stall && cyc < 20) begin
      cyc++;
      step();
    end
    b_idle();
  endtask

  task automatic b_store(input logic [31:0] addr, input logic [31:0] data);
    int c;
    bus_b.i_dMem_Addr      = addr;
    bus_b.i_dMem_DataWrite = data;
    bus_b.i_dMem_ByteEn    = 4'hF;
    bus_b.i_dMem_WriteEn   = 1'b1;
    b_run(c);
    chk("b_store_stall", c, 3);
  endtask

  initial begin
    a_idle();
    b_idle();
    repeat (3) step();
    chk("rst_a_idata", bus_a.o_iMem_Data, 32'h0000_0013);
    chk("rst_a_ddata", bus_a.o_dMem_DataRead, 32'h0);
    chk("rst_a_stall", bus_a.o_Stall, 0);
    chk("rst_a_fault", bus_a.o_Fault, 0);
    chk("rst_b_stall", bus_b.o_Stall, 0);
`ifdef KAYRV32_MEM_PERFCNT_EN
    chk("rst_a_acc", acc_a, 0);
    chk("rst_a_stl", stl_a, 0);
`endif
    rst_n = 1'b1;
    step();

    // Zero-wait fetch after preloading word 0
    a_store(32'h0, 32'hDEAD_BEEF, 4'hF);
    bus_a.i_iMem_Addr   = 32'h0;
    bus_a.i_iMem_ReadEn = 1'b1;
    step();
    a_idle();
    chk("a_fetch0", bus_a.o_iMem_Data, 32'hDEAD_BEEF);
    chk("a_fetch0_stall", bus_a.o_Stall, 0);

    // Partial byte-lane store
    a_store(32'h10, 32'hAAAA_AAAA, 4'hF);
    a_store(32'h10, 32'h1122_3344, 4'b0101);
    a_load(32'h10);
    chk("a_byteen", bus_a.o_dMem_DataRead, 32'hAA22_AA44);
    chk("a_byteen_fault", bus_a.o_Fault, 0);

    // Same-cycle fetch/load conflict
    a_store(32'h4, 32'h1111_1111, 4'hF);
    a_store(32'h8, 32'h2222_2222, 4'hF);
    bus_a.i_iMem_Addr   = 32'h4;
    bus_a.i_iMem_ReadEn = 1'b1;
    bus_a.i_dMem_Addr   = 32'h8;
    bus_a.i_dMem_ReadEn = 1'b1;
    step();
    chk("cfl_ddata", bus_a.o_dMem_DataRead, 32'h2222_2222);
    chk("cfl_stall1", bus_a.o_Stall, 1);
    chk("cfl_idata_hold", bus_a.o_iMem_Data, 32'hDEAD_BEEF);
    step();
    a_idle();
    chk("cfl_stall2", bus_a.o_Stall, 0);
    chk("cfl_idata", bus_a.o_iMem_Data, 32'h1111_1111);
    chk("cfl_ddata_hold", bus_a.o_dMem_DataRead, 32'h2222_2222);

    // Out-of-range load
    a_load(32'h1000);
    chk("oor_ddata", bus_a.o_dMem_DataRead, 32'h0);
    chk("oor_fault", bus_a.o_Fault, 1);
    step();
    chk("oor_fault_end", bus_a.o_Fault, 0);

    // ReadEn+WriteEn together acts as a faulting store
    a_load(32'h8);
    bus_a.i_dMem_Addr      = 32'h8;
    bus_a.i_dMem_DataWrite = 32'h5555_5555;
    bus_a.i_dMem_ByteEn    = 4'hF;
    bus_a.i_dMem_ReadEn    = 1'b1;
    bus_a.i_dMem_WriteEn   = 1'b1;
    step();
    a_idle();
    chk("rw_ddata", bus_a.o_dMem_DataRead, 32'h2222_2222);
    chk("rw_fault", bus_a.o_Fault, 1);
    a_load(32'h8);
    chk("rw_stored", bus_a.o_dMem_DataRead, 32'h5555_5555);

    // ByteEn=0000 is a silent no-op
    a_store(32'h8, 32'h0, 4'h0);
    chk("be0_fault", bus_a.o_Fault, 0);
    a_load(32'h8);
    chk("be0_data", bus_a.o_dMem_DataRead, 32'h5555_5555);

    // Three wait states on instance B
    b_store(32'h20, 32'hCAFE_F00D);
    bus_b.i_dMem_Addr   = 32'h20;
    bus_b.i_dMem_ReadEn = 1'b1;
    b_run(n);
    chk("ws3_load_stall", n, 3);
    chk("ws3_load_data", bus_b.o_dMem_DataRead, 32'hCAFE_F00D);
    b_store(32'h24, 32'h1234_5678);
    bus_b.i_iMem_Addr   = 32'h24;
    bus_b.i_iMem_ReadEn = 1'b1;
    bus_b.i_dMem_Addr   = 32'h20;
    bus_b.i_dMem_ReadEn = 1'b1;
    b_run(n);
    chk("ws3_cfl_stall", n, 4);
    chk("ws3_cfl_ddata", bus_b.o_dMem_DataRead, 32'hCAFE_F00D);
    chk("ws3_cfl_idata", bus_b.o_iMem_Data, 32'h1234_5678);

    // Reset in WAIT drops the pending store
    bus_b.i_dMem_Addr      = 32'h20;
    bus_b.i_dMem_DataWrite = 32'h0;
    bus_b.i_dMem_ByteEn    = 4'hF;
    bus_b.i_dMem_WriteEn   = 1'b1;
    step();
    chk("rstw_stall_pre", bus_b.o_Stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_stall_async", bus_b.o_Stall, 0);
    b_idle();
    a_idle();
    step();
    chk("rstw_idata", bus_b.o_iMem_Data, 32'h0000_0013);
    rst_n = 1'b1;
    step();
    bus_b.i_dMem_Addr   = 32'h20;
    bus_b.i_dMem_ReadEn = 1'b1;
    b_run(n);
    chk("rstw_nowrite_stall", n, 3);
    chk("rstw_nowrite_data", bus_b.o_dMem_DataRead, 32'hCAFE_F00D);
`ifdef KAYRV32_MEM_PERFCNT_EN
    chk("perf_b_acc", acc_b, 1);
    chk("perf_b_stl", stl_b, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
